decode_stage_hz: RTL and testbench
==================================

// Module: decode_stage_hz
// PURPOSE
//   Parametrised ID stage with integrated hazard handling. Holds the regfile (with
//   WB->ID write-through bypass), main control decode, sign extension, a load-use
//   hazard detector, a flush path for taken branches, and the ID/EX pipeline register.
//   Sits between the IF/ID latch and EX; its id_stall output freezes PC and IF/ID.
// PARAMETERS
//   DATA_W      32  datapath width; immediate sign-extended to DATA_W
//   REG_ADDR_W  5   register specifier width; NUM_REGS = 2**REG_ADDR_W
//   CNT_W       16  width of the saturating stall counter
// PORTS
//   clk                      in   1           rising-edge clock
//   rst                      in   1           synchronous, active-low reset
//   wb_reg_write             in   1           RegWrite from MEM/WB
//   wb_write_reg_location    in   REG_ADDR_W  destination register from MEM/WB
//   mem_wb_write_data        in   DATA_W      write data from MEM/WB
//   if_id_instr              in   32          instruction from IF/ID
//   if_id_npc                in   DATA_W      next PC from IF/ID
//   if_id_valid              in   1           IF/ID holds a real instruction
//   ex_flush                 in   1           taken branch resolved in EX; kill ID
//   id_stall                 out  1           comb.; hold PC and IF/ID this cycle
//   id_ex_valid              out  1           ID/EX holds a real instruction
//   id_ex_wb                 out  2           {RegWrite, MemtoReg}
//   id_ex_mem                out  3           {Branch, MemRead, MemWrite}
//   id_ex_execute            out  4           {RegDst, ALUOp[1:0], ALUSrc}
//   id_ex_npc/readdat1/readdat2/sign_ext  out DATA_W  registered datapath values
//   id_ex_instr_bits_25_21/20_16/15_11    out REG_ADDR_W  rs/rt/rd for fwd/dest mux
//   stall_count              out  CNT_W       number of load-use stall cycles
// BEHAVIOUR
//   Reset (rst==0 at posedge): all ID/EX outputs 0, all registers 0, stall_count 0.
//   Regfile: write at posedge when wb_reg_write && addr!=0; reg 0 reads 0 always.
//     Reads comb.; if wb_reg_write && wb addr==read addr && addr!=0, read returns
//     mem_wb_write_data the same cycle (bypass).
//   Decode (opcode [31:26]) -> wb/mem/ex:
//     000000 R:  wb=10 mem=000 ex=1100 | 100011 lw: wb=11 mem=010 ex=0001
//     101011 sw: wb=00 mem=001 ex=0001 | 000100 beq: wb=00 mem=100 ex=0010
//     any other opcode, or if_id_valid==0: all control 0 (NOP).
//   Hazard: hz = id_ex_valid && id_ex_mem[1] && id_ex rt!=0 && if_id_valid &&
//     (id_ex rt == instr[25:21] || id_ex rt == instr[20:16]).
//   id_stall = hz && !ex_flush (combinational).
//   Per posedge, priority: reset > ex_flush > hz > normal.
//     flush or hz: load bubble (control fields 0, id_ex_valid 0); data fields load
//       normally. Normal: load decoded controls, id_ex_valid=if_id_valid, data.
//   Latency: one cycle IF/ID -> ID/EX. Load-use costs exactly one bubble: next cycle
//     the load has left ID/EX, hz drops, held instruction issues.
//   stall_count increments on each cycle with id_stall==1; saturates at all-ones.
//   Regfile write and ID/EX load in the same edge are independent; bypass makes a
//     same-cycle WB value visible to the instruction being latched.
// TESTING
//   1 Reset: rst=0 two cycles with random inputs -> all outputs 0, id_stall 0.
//   2 WB bypass: wb writes r5=0xDEADBEEF while instr reads rs=r5 -> readdat1=DEADBEEF
//     next cycle; write to r0 -> r0 still reads 0.
//   3 Load-use: lw r2,0(r1) then add r3,r2,r4 -> id_stall=1 one cycle, one bubble
//     (valid 0, ctl 0), add issues next cycle, stall_count=1.
//   4 Flush+hazard same cycle: ex_flush=1 with hz true -> id_stall=0, bubble loaded.
//   5 Decode table: each of R/lw/sw/beq and opcode 001111 -> exact wb/mem/ex values.
//   6 Saturation (CNT_W=2): 5 stall cycles -> stall_count=3; lw to r0 -> no stall.

Source files
------------

// File: rtl/decode_stage_hz.sv
// decode_stage_hz: ID stage holding the regfile with WB bypass, control decode, load-use
// hazard detection, branch flush and the ID/EX pipeline register.
module decode_stage_hz #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg_location,
    input  logic [DATA_W-1:0]     mem_wb_write_data,
    input  logic [31:0]           if_id_instr,
    input  logic [DATA_W-1:0]     if_id_npc,
    input  logic                  if_id_valid,
    input  logic                  ex_flush,
    output logic                  id_stall,
    output logic                  id_ex_valid,
    output logic [1:0]            id_ex_wb,
    output logic [2:0]            id_ex_mem,
    output logic [3:0]            id_ex_execute,
    output logic [DATA_W-1:0]     id_ex_npc,
    output logic [DATA_W-1:0]     id_ex_readdat1,
    output logic [DATA_W-1:0]     id_ex_readdat2,
    output logic [DATA_W-1:0]     id_ex_sign_ext,
    output logic [REG_ADDR_W-1:0] id_ex_instr_bits_25_21,
    output logic [REG_ADDR_W-1:0] id_ex_instr_bits_20_16,
    output logic [REG_ADDR_W-1:0] id_ex_instr_bits_15_11,
    output logic [CNT_W-1:0]      stall_count
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     rd1, rd2;
    logic [5:0]            op;
    logic [8:0]            ctl;
    logic                  hz, bubble;

    assign op = if_id_instr[31:26];
    assign rs = REG_ADDR_W'(if_id_instr[25:21]);
    assign rt = REG_ADDR_W'(if_id_instr[20:16]);
    assign rd = REG_ADDR_W'(if_id_instr[15:11]);

    // Write-through: a value retiring this cycle is visible to the instruction being decoded
    assign rd1 = rs == '0 ? '0 :
                 (wb_reg_write && wb_write_reg_location == rs) ? mem_wb_write_data : regs[rs];
    assign rd2 = rt == '0 ? '0 :
                 (wb_reg_write && wb_write_reg_location == rt) ? mem_wb_write_data : regs[rt];

    // {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp[1:0], ALUSrc}
    always_comb begin
        ctl = !if_id_valid     ? 9'b00_000_0000 :
              op == 6'b000000 ? 9'b10_000_1100 :
              op == 6'b100011 ? 9'b11_010_0001 :
              op == 6'b101011 ? 9'b00_001_0001 :
              op == 6'b000100 ? 9'b00_100_0010 : 9'b00_000_0000;
    end

    assign hz = id_ex_valid && id_ex_mem[1] && id_ex_instr_bits_20_16 != '0 && if_id_valid &&
                (id_ex_instr_bits_20_16 == rs || id_ex_instr_bits_20_16 == rt);
    assign id_stall = hz && !ex_flush;
    assign bubble   = ex_flush || hz;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_reg_write && wb_write_reg_location != '0) begin
            regs[wb_write_reg_location] <= mem_wb_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ex_valid                                <= 1'b0;
            {id_ex_wb, id_ex_mem, id_ex_execute}       <= '0;
            id_ex_npc                                  <= '0;
            id_ex_readdat1                             <= '0;
            id_ex_readdat2                             <= '0;
            id_ex_sign_ext                             <= '0;
            id_ex_instr_bits_25_21                     <= '0;
            id_ex_instr_bits_20_16                     <= '0;
            id_ex_instr_bits_15_11                     <= '0;
            stall_count                                <= '0;
        end else begin
            id_ex_valid                                <= bubble ? 1'b0 : if_id_valid;
            {id_ex_wb, id_ex_mem, id_ex_execute}       <= bubble ? 9'd0 : ctl;
            id_ex_npc                                  <= if_id_npc;
            id_ex_readdat1                             <= rd1;
            id_ex_readdat2                             <= rd2;
            id_ex_sign_ext                             <= DATA_W'($signed(if_id_instr[15:0]));
            id_ex_instr_bits_25_21                     <= rs;
            id_ex_instr_bits_20_16                     <= rt;
            id_ex_instr_bits_15_11                     <= rd;
            if (id_stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_decode_stage_hz.sv
// tb_decode_stage_hz: directed vectors feed a scoreboard queue; a monitor pops and compares
// the ID/EX register after each edge, with a CNT_W=2 copy checking counter saturation.
module tb_decode_stage_hz;
    logic        clk = 0;
    logic        rst;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg_location;
    logic [31:0] mem_wb_write_data, if_id_instr, if_id_npc;
    logic        if_id_valid, ex_flush;

    logic        id_stall, id_ex_valid;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_execute;
    logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [4:0]  b25, b20, b15;
    logic [15:0] stall_count;

    logic        s_stall, s_valid;
    logic [1:0]  s_wb;
    logic [2:0]  s_mem;
    logic [3:0]  s_ex;
    logic [31:0] s_npc, s_rd1, s_rd2, s_sx;
    logic [4:0]  s25, s20, s15;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    decode_stage_hz dut (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write),
        .wb_write_reg_location(wb_write_reg_location), .mem_wb_write_data(mem_wb_write_data),
        .if_id_instr(if_id_instr), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid),
        .ex_flush(ex_flush), .id_stall(id_stall), .id_ex_valid(id_ex_valid),
        .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem), .id_ex_execute(id_ex_execute),
        .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
        .id_ex_sign_ext(id_ex_sign_ext), .id_ex_instr_bits_25_21(b25),
        .id_ex_instr_bits_20_16(b20), .id_ex_instr_bits_15_11(b15), .stall_count(stall_count)
    );

    decode_stage_hz #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write),
        .wb_write_reg_location(wb_write_reg_location), .mem_wb_write_data(mem_wb_write_data),
        .if_id_instr(if_id_instr), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid),
        .ex_flush(ex_flush), .id_stall(s_stall), .id_ex_valid(s_valid),
        .id_ex_wb(s_wb), .id_ex_mem(s_mem), .id_ex_execute(s_ex),
        .id_ex_npc(s_npc), .id_ex_readdat1(s_rd1), .id_ex_readdat2(s_rd2),
        .id_ex_sign_ext(s_sx), .id_ex_instr_bits_25_21(s25),
        .id_ex_instr_bits_20_16(s20), .id_ex_instr_bits_15_11(s15), .stall_count(s_cnt)
    );

    typedef struct {
        logic        cs;
        logic        st;
        logic        v;
        logic [8:0]  ctl;
        logic [31:0] npc, rd1, rd2, sx;
        logic [14:0] rr;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0;
    logic [15:0] ecnt = 0;
    logic [31:0] npc_n = 32'h1000;

    localparam logic [8:0] C_R = 9'b10_000_1100, C_LW = 9'b11_010_0001,
                           C_SW = 9'b00_001_0001, C_BEQ = 9'b00_100_0010, C_0 = 9'd0;

    function automatic logic [31:0] r_i(input logic [4:0] s, t, d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic cyc(input logic [31:0] ins, input logic vld, fl, wbw, input logic [4:0] wba,
                       input logic [31:0] wbd, input logic ev, input logic [8:0] ectl,
                       input logic [31:0] erd1, erd2, input logic est);
        exp_t e;
        @(negedge clk);
        rst = 1; if_id_instr = ins; if_id_valid = vld; ex_flush = fl;
        wb_reg_write = wbw; wb_write_reg_location = wba; mem_wb_write_data = wbd;
        if_id_npc = npc_n;
        if (est) ecnt++;
        e.cs = 1; e.st = est; e.v = ev; e.ctl = ectl; e.npc = npc_n; e.rd1 = erd1; e.rd2 = erd2;
        e.sx = {{16{ins[15]}}, ins[15:0]}; e.rr = ins[25:11]; e.cnt = ecnt;
        e.cnt2 = ecnt > 3 ? 2'd3 : ecnt[1:0];
        q.push_back(e);
        npc_n += 4;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3 e.st = id_stall;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t x;
                x = q.pop_front();
                if (x.cs) chk("id_stall", {31'd0, e.st}, {31'd0, x.st});
                chk("id_ex_valid", {31'd0, id_ex_valid}, {31'd0, x.v});
                chk("ctl", {23'd0, id_ex_wb, id_ex_mem, id_ex_execute}, {23'd0, x.ctl});
                chk("npc", id_ex_npc, x.npc);
                chk("readdat1", id_ex_readdat1, x.rd1);
                chk("readdat2", id_ex_readdat2, x.rd2);
                chk("sign_ext", id_ex_sign_ext, x.sx);
                chk("rs_rt_rd", {17'd0, b25, b20, b15}, {17'd0, x.rr});
                chk("stall_count", {16'd0, stall_count}, {16'd0, x.cnt});
                chk("stall_count_sat", {30'd0, s_cnt}, {30'd0, x.cnt2});
            end
        end
    end

    initial begin
        exp_t z;
        rst = 0; wb_reg_write = 0; wb_write_reg_location = 0; mem_wb_write_data = 0;
        if_id_instr = 0; if_id_npc = 0; if_id_valid = 0; ex_flush = 0;
        z = '{cs: 0, st: 0, v: 0, ctl: 0, npc: 0, rd1: 0, rd2: 0, sx: 0, rr: 0, cnt: 0, cnt2: 0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 0; wb_reg_write = 1'($urandom); wb_write_reg_location = 5'($urandom);
            mem_wb_write_data = $urandom; if_id_instr = $urandom; if_id_npc = $urandom;
            if_id_valid = 1'($urandom); ex_flush = 1'($urandom);
            z.cs = (i == 1);
            q.push_back(z);
        end
        // bypass and r0
        cyc(r_i(5, 0, 6), 1, 0, 1, 5, 32'hDEADBEEF, 1, C_R, 32'hDEADBEEF, 0, 0);
        cyc(r_i(0, 5, 7), 1, 0, 1, 0, 32'h12345678, 1, C_R, 0, 32'hDEADBEEF, 0);
        cyc(r_i(1, 5, 1), 1, 0, 1, 1, 32'h100, 1, C_R, 32'h100, 32'hDEADBEEF, 0);
        // decode table
        cyc(i_i(6'b101011, 0, 0, 16'hFFFC), 1, 0, 0, 0, 0, 1, C_SW, 0, 0, 0);
        cyc(i_i(6'b000100, 1, 5, 16'h0004), 1, 0, 0, 0, 0, 1, C_BEQ, 32'h100, 32'hDEADBEEF, 0);
        cyc(i_i(6'b001111, 0, 9, 16'h1234), 1, 0, 0, 0, 0, 1, C_0, 0, 0, 0);
        cyc(r_i(1, 5, 2), 0, 0, 0, 0, 0, 0, C_0, 32'h100, 32'hDEADBEEF, 0);
        // load-use: lw r2,0(r1); add r3,r2,r4 with r2 retiring during the stall
        cyc(i_i(6'b100011, 1, 2, 16'h0000), 1, 0, 1, 4, 32'h44, 1, C_LW, 32'h100, 0, 0);
        cyc(r_i(2, 4, 3), 1, 0, 1, 2, 32'h22, 0, C_0, 32'h22, 32'h44, 1);
        cyc(r_i(2, 4, 3), 1, 0, 0, 0, 0, 1, C_R, 32'h22, 32'h44, 0);
        // flush wins over hazard
        cyc(i_i(6'b100011, 0, 6, 16'h0004), 1, 0, 0, 0, 0, 1, C_LW, 0, 0, 0);
        cyc(r_i(6, 0, 8), 1, 1, 0, 0, 0, 0, C_0, 0, 0, 0);
        cyc(r_i(6, 0, 8), 1, 0, 0, 0, 0, 1, C_R, 0, 0, 0);
        // load to r0 never stalls
        cyc(i_i(6'b100011, 1, 0, 16'h0000), 1, 0, 0, 0, 0, 1, C_LW, 32'h100, 0, 0);
        cyc(r_i(0, 0, 2), 1, 0, 0, 0, 0, 1, C_R, 0, 0, 0);
        // four more stalls push the 2-bit counter past saturation
        for (int k = 0; k < 4; k++) begin
            logic [31:0] u;
            u = k[0] ? r_i(0, 7, 3) : r_i(7, 0, 3);
            cyc(i_i(6'b100011, 0, 7, 16'h8000), 1, 0, 0, 0, 0, 1, C_LW, 0, 0, 0);
            cyc(u, 1, 0, 0, 0, 0, 0, C_0, 0, 0, 1);
            cyc(u, 1, 0, 0, 0, 0, 1, C_R, 0, 0, 0);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
